// File: rtl/clksw_pkg.sv
// ---------------------------------------------------------------------------
// clksw_pkg
// Shared definitions for the CPU clock switcher: the FSM state encoding,
// default parameter values used by the top, the bus glue and the bench, and
// small helpers that decode a state into its clock/host-alignment meaning.
// ---------------------------------------------------------------------------
package clksw_pkg;

  // hsclk cycles per fast half-period (8MHz CPU clock from 32MHz)
  localparam int FAST_DIV_DEF    = 2;
  // flops in the phi0 synchroniser
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    LO       = 2'd0,  // CPU clock low, counting the minimum phi1 time
    HI_FAST  = 2'd1,  // CPU clock high, fast cycle
    WAIT_BBC = 2'd2,  // CPU clock held low until a fresh phi0 rise
    HI_SLOW  = 2'd3   // CPU clock high, follows host phi0
  } clksw_state_t;

  // CPU clock level implied by a state
  function automatic logic state_is_high(input clksw_state_t s);
    return (s == HI_FAST) || (s == HI_SLOW);
  endfunction

  // Host-aligned cycle indication implied by a state
  function automatic logic state_is_bbc(input clksw_state_t s);
    return (s == WAIT_BBC) || (s == HI_SLOW);
  endfunction

endpackage

// File: rtl/cpu_clkswitch_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// N-stage synchroniser for an asynchronous level plus a history flop, giving
// the synchronised level and single-cycle rise/fall pulses. Rise and fall
// compare the same two flops with opposite polarity, so they never coincide.
// Ports:
//   clk    - sampling clock
//   resetb - synchronous active-low reset, clears every flop to 0
//   d      - asynchronous input
//   level  - synchronised level (output of last synchroniser stage)
//   rise   - 1 for one clk when level goes 0->1
//   fall   - 1 for one clk when level goes 1->0
// ---------------------------------------------------------------------------
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // Synchroniser chain and one-cycle history of the synchronised level
  always_ff @(posedge clk) begin
    if (!resetb) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = level & ~hist_r;
  assign fall  = ~level & hist_r;

endmodule

// File: rtl/cpu_clkswitch.sv
// ---------------------------------------------------------------------------
// cpu_clkswitch
// Generates the 65816 CPU clock, switching cycle by cycle between a fast
// clock divided from hsclk and the host 2MHz phi0. All switching happens
// while the CPU clock is low, so no runt pulses are produced.
// Parameters:
//   FAST_DIV    - hsclk cycles per fast half-period (>= 2)
//   SYNC_STAGES - phi0 synchroniser depth (>= 2)
// Ports:
//   hsclk        - board oscillator, the only clock
//   resetb       - synchronous active-low reset
//   bbc_ck2_phi0 - host phi0, asynchronous to hsclk
//   sel_fast     - per-cycle fast request, sampled only at the decision point
//   cpu_ck_phi2  - CPU clock (registered)
//   cpu_ck_phi1  - registered inverse of cpu_ck_phi2
//   bbc_cycle    - current/pending CPU cycle is host-aligned
//   cycle_end    - one-hsclk pulse on each CPU clock falling edge
// ---------------------------------------------------------------------------
module cpu_clkswitch
  import clksw_pkg::*;
#(
  parameter int FAST_DIV    = FAST_DIV_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic hsclk,
  input  logic resetb,
  input  logic bbc_ck2_phi0,
  input  logic sel_fast,
  output logic cpu_ck_phi2,
  output logic cpu_ck_phi1,
  output logic bbc_cycle,
  output logic cycle_end
);

  localparam int               CNT_W    = $clog2(FAST_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  clksw_state_t     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             cycle_end_s;

  logic             phi2_r, phi1_r, bbc_r, cycle_end_r;

  logic             p0_level_s, p0_rise_s, p0_fall_s;
  logic [SYNC_STAGES-1:0] fill_r;
  logic             armed_r;
  logic             rise_ok_s;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (hsclk),
    .resetb (resetb),
    .d      (bbc_ck2_phi0),
    .level  (p0_level_s),
    .rise   (p0_rise_s),
    .fall   (p0_fall_s)
  );

  // After reset the synchroniser holds zeros that do not reflect phi0. If
  // phi0 is already high at release, the first real sample would look like
  // a rise. fill_r marks when the synchronised level holds a real sample;
  // rises are only accepted once a real low level has been seen.
  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      fill_r  <= '0;
      armed_r <= 1'b0;
    end else begin
      fill_r  <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      armed_r <= armed_r | (fill_r[SYNC_STAGES-1] & ~p0_level_s);
    end
  end

  assign rise_ok_s = p0_rise_s & armed_r;

  // FSM state and phase counter
  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      state_r <= WAIT_BBC;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; the fast/slow decision is taken once, at the end of
  // the minimum low time, and never revisited
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cycle_end_s = 1'b0;
    case (state_r)
      LO: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (sel_fast) begin
            state_s = HI_FAST;
          end else begin
            state_s = WAIT_BBC;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HI_FAST: begin
        if (cnt_r == CNT_LAST) begin
          state_s     = LO;
          cnt_s       = '0;
          cycle_end_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_BBC: begin
        if (rise_ok_s) begin
          state_s = HI_SLOW;
        end else begin
          state_s = WAIT_BBC;
        end
      end
      HI_SLOW: begin
        if (p0_fall_s) begin
          state_s     = LO;
          cnt_s       = '0;
          cycle_end_s = 1'b1;
        end else begin
          state_s = HI_SLOW;
        end
      end
      default: begin
        state_s = WAIT_BBC;
        cnt_s   = '0;
      end
    endcase
  end

  // Output registers decoded from the next state so they change together
  // with the state register
  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      phi2_r      <= 1'b0;
      phi1_r      <= 1'b1;
      bbc_r       <= 1'b1;
      cycle_end_r <= 1'b0;
    end else begin
      phi2_r      <= state_is_high(state_s);
      phi1_r      <= ~state_is_high(state_s);
      bbc_r       <= state_is_bbc(state_s);
      cycle_end_r <= cycle_end_s;
    end
  end

  assign cpu_ck_phi2 = phi2_r;
  assign cpu_ck_phi1 = phi1_r;
  assign bbc_cycle   = bbc_r;
  assign cycle_end   = cycle_end_r;

endmodule

// File: tb/tb_cpu_clkswitch.sv
// ---------------------------------------------------------------------------
// tb_cpu_clkswitch
// Randomised bench for cpu_clkswitch. A reference model works on the recorded
// history of phi0 and sel_fast samples and predicts each CPU cycle as a pair
// of absolute hsclk edge numbers (clock rise, clock fall) plus its host-aligned
// flag. Predictions go into a queue; a monitor measures the real clock and
// pops one prediction per cycle_end pulse.
// ---------------------------------------------------------------------------
module tb_cpu_clkswitch;
  import clksw_pkg::*;

  localparam int FD   = FAST_DIV_DEF;
  localparam int NS   = SYNC_STAGES_DEF;
  localparam int MAXE = 16384;

  logic hsclk, resetb, bbc_ck2_phi0, sel_fast;
  logic cpu_ck_phi2, cpu_ck_phi1, bbc_cycle, cycle_end;

  cpu_clkswitch #(
    .FAST_DIV    (FD),
    .SYNC_STAGES (NS)
  ) dut (
    .hsclk        (hsclk),
    .resetb       (resetb),
    .bbc_ck2_phi0 (bbc_ck2_phi0),
    .sel_fast     (sel_fast),
    .cpu_ck_phi2  (cpu_ck_phi2),
    .cpu_ck_phi1  (cpu_ck_phi1),
    .bbc_cycle    (bbc_cycle),
    .cycle_end    (cycle_end)
  );

  typedef struct {
    int hs;
    int he;
    bit bbc;
  } txn_t;

  txn_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // model state (all times are absolute edge numbers)
  int ec = 0;
  bit ph [MAXE];
  int m_rel = 1000000;
  int m_e0 = -1;
  int m_hs = -1;
  bit m_fast = 1'b0;
  bit m_wait = 1'b1;
  bit exp_hi = 1'b0;
  bit exp_bbc = 1'b1;
  bit exp_ce = 1'b0;
  bit rst_seen = 1'b1;

  // stimulus controls
  int p0_half = 8;
  bit p0_rand = 1'b0;
  int sel_mode = 0;

  // monitor state
  int   o_hs = -1;
  int   o_e0 = -1;
  bit   o_bbc = 1'b0;
  logic prev_phi2 = 1'b0;

  task automatic check(input string name, input bit ok, input longint act, input longint expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, ec);
  endtask

  initial hsclk = 1'b0;
  always #5 hsclk = ~hsclk;

  // phi0 generator: nominal 8/8 hsclk, optionally random half periods
  initial begin
    bbc_ck2_phi0 = 1'b0;
    forever begin
      repeat (p0_half) @(negedge hsclk);
      bbc_ck2_phi0 = ~bbc_ck2_phi0;
      if (p0_rand) p0_half = $urandom_range(5, 11);
    end
  end

  // sel_fast driver
  initial begin
    sel_fast = 1'b0;
    forever begin
      @(negedge hsclk);
      case (sel_mode)
        0: sel_fast = 1'b0;
        1: sel_fast = 1'b1;
        2: sel_fast = $urandom_range(0, 1) == 1;
        default: sel_fast = $urandom_range(0, 7) != 0;
      endcase
    end
  end

  // Reference model: the DUT sees phi0 sampled at edge k as its synchronised
  // level after edge k+NS-1, so a rise acted on at edge e is ph[e-NS]=1 with
  // ph[e-NS-1]=0; both samples must have been taken out of reset.
  always @(posedge hsclk) begin
    bit real_h, rise, fall;
    ec = ec + 1;
    ph[ec] = bbc_ck2_phi0;
    rst_seen = !resetb;
    if (!resetb) begin
      m_rel = ec + 1;
      m_wait = 1'b1;
      m_hs = -1;
      m_e0 = -1;
      exp_hi = 1'b0;
      exp_bbc = 1'b1;
      exp_ce = 1'b0;
    end else begin
      exp_ce = 1'b0;
      rise = 1'b0;
      fall = 1'b0;
      real_h = (ec - NS - 1) >= m_rel;
      if (real_h) begin
        rise = ph[ec-NS] && !ph[ec-NS-1];
        fall = !ph[ec-NS] && ph[ec-NS-1];
      end
      if (m_wait) begin
        if (rise) begin
          m_wait = 1'b0;
          m_hs = ec;
          m_fast = 1'b0;
        end
      end else if (m_hs >= 0) begin
        if ((m_fast && ec == m_hs + FD) || (!m_fast && fall)) begin
          sb_q.push_back('{hs: m_hs, he: ec, bbc: !m_fast});
          m_e0 = ec;
          m_hs = -1;
          exp_ce = 1'b1;
        end
      end else if (ec == m_e0 + FD) begin
        if (sel_fast) begin
          m_hs = ec;
          m_fast = 1'b1;
        end else begin
          m_wait = 1'b1;
        end
      end
      exp_hi = (m_hs >= 0);
      exp_bbc = m_wait || (m_hs >= 0 && !m_fast);
    end
  end

  // Monitor: per-edge output levels plus one transaction per cycle_end
  always @(negedge hsclk) begin
    txn_t t;
    check("phi2", cpu_ck_phi2 === exp_hi, cpu_ck_phi2, exp_hi);
    check("phi1", cpu_ck_phi1 === !exp_hi, cpu_ck_phi1, !exp_hi);
    check("bbc_cycle", bbc_cycle === exp_bbc, bbc_cycle, exp_bbc);
    check("cycle_end", cycle_end === exp_ce, cycle_end, exp_ce);
    if (rst_seen) begin
      o_hs = -1;
      o_e0 = -1;
    end else begin
      if (cpu_ck_phi2 === 1'b1 && prev_phi2 !== 1'b1) begin
        o_hs = ec;
        o_bbc = bbc_cycle;
        if (o_e0 >= 0) check("min_low", (ec - o_e0) >= FD, ec - o_e0, FD);
      end
      if (cycle_end === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_cycle", 1'b0, ec, -1);
        end else begin
          t = sb_q.pop_front();
          check("txn_rise_edge", o_hs == t.hs, o_hs, t.hs);
          check("txn_fall_edge", ec == t.he, ec, t.he);
          check("txn_bbc", o_bbc == t.bbc, o_bbc, t.bbc);
          check("min_high", (ec - o_hs) >= FD, ec - o_hs, FD);
        end
        o_e0 = ec;
      end
    end
    prev_phi2 = cpu_ck_phi2;
  end

  task automatic run(input int n);
    repeat (n) @(negedge hsclk);
  endtask

  // Assert reset at the current negedge, check the next edge, then release
  task automatic reset_now(input string tag, input int hold);
    resetb = 1'b0;
    @(negedge hsclk);
    check({tag, "_phi2"}, cpu_ck_phi2 === 1'b0, cpu_ck_phi2, 0);
    check({tag, "_bbc"}, bbc_cycle === 1'b1, bbc_cycle, 1);
    check({tag, "_cycle_end"}, cycle_end === 1'b0, cycle_end, 0);
    repeat (hold) @(negedge hsclk);
    resetb = 1'b1;
  endtask

  initial begin
    bit found;
    resetb = 1'b0;
    run(5);
    resetb = 1'b1;

    // host-aligned cycles only
    sel_mode = 0;
    run(200);
    // fast cycles held
    sel_mode = 1;
    run(200);
    // sel_fast randomly toggling every hsclk
    sel_mode = 2;
    run(400);
    // mostly fast with occasional slow requests
    sel_mode = 3;
    run(400);

    // reset while the clock is high on a fast cycle
    sel_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge hsclk);
      found = (m_hs >= 0) && m_fast && (m_hs == ec);
    end
    check("wait_hi_fast", found, found, 1);
    if (found) reset_now("rst_hi_fast", $urandom_range(1, 6));
    run(200);

    // reset while the clock is high on a host-aligned cycle
    sel_mode = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge hsclk);
      found = (m_hs >= 0) && !m_fast && (ec == m_hs + 2);
    end
    check("wait_hi_slow", found, found, 1);
    if (found) reset_now("rst_hi_slow", $urandom_range(1, 4));
    run(200);

    // irregular phi0 with random requests
    p0_rand = 1'b1;
    sel_mode = 2;
    run(500);
    sel_mode = 3;
    run(300);

    check("sb_drained", sb_q.size() == 0, sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
